// File: rtl/alu_arbiter_if.sv
// Request bundle for one ALU requester: valid/ready handshake plus operands.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
) ();
    logic             valid;
    logic             ready;
    logic [4:0]       control;
    logic [31:0]      pc;
    logic [1:0]       imm_en;
    logic [11:0]      imm;
    logic [19:0]      imm_u_j;
    logic [31:0]      in_1;
    logic [31:0]      in_2;
    logic [TAG_W-1:0] tag;

    modport master (
        output valid, control, pc, imm_en, imm, imm_u_j, in_1, in_2, tag,
        input  ready
    );

    modport slave (
        input  valid, control, pc, imm_en, imm, imm_u_j, in_1, in_2, tag,
        output ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port issue arbiter for the shared ALU.
// Control goes out in the grant cycle, operands one cycle later, result two.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     req0,
    alu_arbiter_if.slave     req1,
    input  logic             hold,
    input  logic             flush,
    output logic [4:0]       alu_control,
    output logic [31:0]      alu_pc,
    output logic [1:0]       alu_imm_en,
    output logic [11:0]      alu_imm,
    output logic [19:0]      alu_imm_u_j,
    output logic [31:0]      alu_in_1,
    output logic [31:0]      alu_in_2,
    input  logic [31:0]      alu_out,
    input  logic             alu_take_branch,
    output logic             rsp_valid,
    output logic             rsp_port,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_out,
    output logic             rsp_take_branch
);

    logic             pri_q, pri_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_port_q, s1_port_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      s1_in_1_q, s1_in_1_d;
    logic [31:0]      s1_in_2_q, s1_in_2_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_port_q, s2_port_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic g0, g1, open;

    // reset gates the grant so ready drops the moment reset asserts
    always_comb begin
        open = reset & ~hold & ~flush;
        g0   = open & req0.valid & (~pri_q | ~req1.valid);
        g1   = open & req1.valid & (pri_q | ~req0.valid);
    end

    assign req0.ready = g0;
    assign req1.ready = g1;

    always_comb begin
        alu_control = '0;
        alu_pc      = '0;
        alu_imm_en  = '0;
        alu_imm     = '0;
        alu_imm_u_j = '0;
        unique case (1'b1)
            g0: begin
                alu_control = req0.control;
                alu_pc      = req0.pc;
                alu_imm_en  = req0.imm_en;
                alu_imm     = req0.imm;
                alu_imm_u_j = req0.imm_u_j;
            end
            g1: begin
                alu_control = req1.control;
                alu_pc      = req1.pc;
                alu_imm_en  = req1.imm_en;
                alu_imm     = req1.imm;
                alu_imm_u_j = req1.imm_u_j;
            end
            default: ;
        endcase
    end

    always_comb begin
        pri_d      = pri_q;
        s1_valid_d = g0 | g1;
        s1_port_d  = s1_port_q;
        s1_tag_d   = s1_tag_q;
        s1_in_1_d  = s1_in_1_q;
        s1_in_2_d  = s1_in_2_q;
        if (g0) begin
            pri_d     = 1'b1;
            s1_port_d = 1'b0;
            s1_tag_d  = req0.tag;
            s1_in_1_d = req0.in_1;
            s1_in_2_d = req0.in_2;
        end else if (g1) begin
            pri_d     = 1'b0;
            s1_port_d = 1'b1;
            s1_tag_d  = req1.tag;
            s1_in_1_d = req1.in_1;
            s1_in_2_d = req1.in_2;
        end
        s2_valid_d = s1_valid_q & ~flush;
        s2_port_d  = s1_port_q;
        s2_tag_d   = s1_tag_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pri_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s1_tag_q   <= '0;
            s1_in_1_q  <= '0;
            s1_in_2_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            pri_q      <= pri_d;
            s1_valid_q <= s1_valid_d;
            s1_port_q  <= s1_port_d;
            s1_tag_q   <= s1_tag_d;
            s1_in_1_q  <= s1_in_1_d;
            s1_in_2_q  <= s1_in_2_d;
            s2_valid_q <= s2_valid_d;
            s2_port_q  <= s2_port_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign alu_in_1        = s1_valid_q ? s1_in_1_q : '0;
    assign alu_in_2        = s1_valid_q ? s1_in_2_q : '0;
    assign rsp_valid       = s2_valid_q;
    assign rsp_port        = s2_port_q;
    assign rsp_tag         = s2_tag_q;
    assign rsp_out         = alu_out;
    assign rsp_take_branch = alu_take_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic against
// a transaction-level model (expected-response queue keyed by due cycle).
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_BLT   = 5'd3;
    localparam logic [4:0] OP_AUIPC = 5'd4;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        flush;
    logic [4:0]  alu_control;
    logic [31:0] alu_pc;
    logic [1:0]  alu_imm_en;
    logic [11:0] alu_imm;
    logic [19:0] alu_imm_u_j;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [31:0] alu_out;
    logic        alu_take_branch;
    logic        rsp_valid;
    logic        rsp_port;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_out;
    logic        rsp_take_branch;

    alu_arbiter_if #(.TAG_W(4)) req0 ();
    alu_arbiter_if #(.TAG_W(4)) req1 ();

    alu_arbiter #(.TAG_W(4)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .req0            (req0),
        .req1            (req1),
        .hold            (hold),
        .flush           (flush),
        .alu_control     (alu_control),
        .alu_pc          (alu_pc),
        .alu_imm_en      (alu_imm_en),
        .alu_imm         (alu_imm),
        .alu_imm_u_j     (alu_imm_u_j),
        .alu_in_1        (alu_in_1),
        .alu_in_2        (alu_in_2),
        .alu_out         (alu_out),
        .alu_take_branch (alu_take_branch),
        .rsp_valid       (rsp_valid),
        .rsp_port        (rsp_port),
        .rsp_tag         (rsp_tag),
        .rsp_out         (rsp_out),
        .rsp_take_branch (rsp_take_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {take_branch, result} for one op, straight from its operands
    function automatic logic [32:0] ref_alu(
        input logic [4:0]  op,
        input logic [31:0] pc,
        input logic [1:0]  en,
        input logic [11:0] imm,
        input logic [19:0] iu,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] op2;
        logic [32:0] r;
        op2 = b;
        if (en == 2'd1) op2 = {{20{imm[11]}}, imm};
        if (en == 2'd2) op2 = {iu, 12'h000};
        r = '0;
        case (op)
            OP_ADD:   r = {1'b0, a + op2};
            OP_SUB:   r = {1'b0, a - op2};
            OP_XOR:   r = {1'b0, a ^ op2};
            OP_BLT:   r = {($signed(a) < $signed(op2)), 32'h0};
            OP_AUIPC: r = {1'b0, pc + {iu, 12'h000}};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // external two-stage ALU with skewed inputs
    logic [4:0]  a_ctl;
    logic [31:0] a_pc;
    logic [1:0]  a_en;
    logic [11:0] a_imm;
    logic [19:0] a_iu;
    always @(posedge clk) begin
        a_ctl <= alu_control;
        a_pc  <= alu_pc;
        a_en  <= alu_imm_en;
        a_imm <= alu_imm;
        a_iu  <= alu_imm_u_j;
        {alu_take_branch, alu_out} <=
            ref_alu(a_ctl, a_pc, a_en, a_imm, a_iu, alu_in_1, alu_in_2);
    end

    typedef struct {
        logic        valid;
        logic [4:0]  control;
        logic [31:0] pc;
        logic [1:0]  imm_en;
        logic [11:0] imm;
        logic [19:0] immu;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  tag;
    } rq_t;

    typedef struct {
        int          due;
        logic        port;
        logic [3:0]  tag;
        logic [31:0] out;
        logic        br;
        logic [31:0] in1;
        logic [31:0] in2;
    } ex_t;

    rq_t  rq [2];
    ex_t  q [$];
    int   cyc;
    int   n_assert;
    int   n_fail;
    logic m_pri;
    logic lastg [2];
    logic [3:0] gseq;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        req0.valid   = rq[0].valid;
        req0.control = rq[0].control;
        req0.pc      = rq[0].pc;
        req0.imm_en  = rq[0].imm_en;
        req0.imm     = rq[0].imm;
        req0.imm_u_j = rq[0].immu;
        req0.in_1    = rq[0].in1;
        req0.in_2    = rq[0].in2;
        req0.tag     = rq[0].tag;
        req1.valid   = rq[1].valid;
        req1.control = rq[1].control;
        req1.pc      = rq[1].pc;
        req1.imm_en  = rq[1].imm_en;
        req1.imm     = rq[1].imm;
        req1.imm_u_j = rq[1].immu;
        req1.in_1    = rq[1].in1;
        req1.in_2    = rq[1].in2;
        req1.tag     = rq[1].tag;
    endtask

    task automatic next_bundle(input int i);
        logic [31:0] r;
        rq[i].valid   = 1'b1;
        rq[i].control = 5'($urandom_range(0, 4));
        rq[i].pc      = $urandom;
        rq[i].imm_en  = 2'($urandom_range(0, 2));
        r = $urandom;
        rq[i].imm     = r[11:0];
        rq[i].immu    = r[31:12];
        rq[i].in1     = $urandom;
        rq[i].in2     = $urandom;
        r = $urandom;
        rq[i].tag     = r[3:0];
    endtask

    // one cycle: check at negedge, advance model, return at posedge+1
    task automatic step();
        logic e0, e1;
        int   w;
        ex_t  e;
        logic [32:0] res;
        apply();
        @(negedge clk);
        e0 = rst_n && !hold && !flush && rq[0].valid &&
             (m_pri == 1'b0 || !rq[1].valid);
        e1 = rst_n && !hold && !flush && rq[1].valid &&
             (m_pri == 1'b1 || !rq[0].valid);
        chk("ready0", 96'(req0.ready), 96'(e0));
        chk("ready1", 96'(req1.ready), 96'(e1));
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", 96'(rsp_valid), 96'(1));
            chk("rsp_port", 96'(rsp_port), 96'(e.port));
            chk("rsp_tag", 96'(rsp_tag), 96'(e.tag));
            chk("rsp_out", 96'(rsp_out), 96'(e.out));
            chk("rsp_br", 96'(rsp_take_branch), 96'(e.br));
        end else begin
            chk("rsp_idle", 96'(rsp_valid), 96'(0));
        end
        w = e1 ? 1 : 0;
        if (e0 || e1)
            chk("stageA",
                96'({alu_control, alu_pc, alu_imm_en, alu_imm, alu_imm_u_j}),
                96'({rq[w].control, rq[w].pc, rq[w].imm_en,
                     rq[w].imm, rq[w].immu}));
        else
            chk("stageA_zero",
                96'({alu_control, alu_pc, alu_imm_en, alu_imm, alu_imm_u_j}),
                96'(0));
        if (q.size() > 0 && q[0].due == cyc + 1)
            chk("stageB", 96'({alu_in_1, alu_in_2}),
                96'({q[0].in1, q[0].in2}));
        else
            chk("stageB_zero", 96'({alu_in_1, alu_in_2}), 96'(0));
        if (flush || !rst_n) q.delete();
        if (!rst_n) m_pri = 1'b0;
        if (e0 || e1) begin
            res = ref_alu(rq[w].control, rq[w].pc, rq[w].imm_en,
                          rq[w].imm, rq[w].immu, rq[w].in1, rq[w].in2);
            e.due  = cyc + 2;
            e.port = e1;
            e.tag  = rq[w].tag;
            e.out  = res[31:0];
            e.br   = res[32];
            e.in1  = rq[w].in1;
            e.in2  = rq[w].in2;
            q.push_back(e);
            m_pri = ~e1;
        end
        lastg[0] = e0;
        lastg[1] = e1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        rq[0].valid = 1'b0;
        rq[1].valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        m_pri    = 1'b0;
        lastg[0] = 1'b0;
        lastg[1] = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        next_bundle(0);
        next_bundle(1);
        apply();

        // reset state, with both ports requesting
        #12;
        chk("rst_ready", 96'({req0.ready, req1.ready}), 96'(0));
        chk("rst_rsp", 96'(rsp_valid), 96'(0));
        chk("rst_alu", 96'({alu_control, alu_pc, alu_in_1, alu_in_2}), 96'(0));
        step();
        rst_n = 1'b1;
        idle(1);

        // single ADD_I: 5 + sext(FFD) = 2
        rq[0] = '{1'b1, OP_ADD, 32'h0, 2'd1, 12'hFFD, 20'h0, 32'd5, 32'd0, 4'd3};
        step();
        rq[0].valid = 1'b0;
        chk("single_in1", 96'(alu_in_1), 96'(5));
        step();
        chk("single_rsp",
            96'({rsp_valid, rsp_port, rsp_tag, rsp_out}),
            96'({1'b1, 1'b0, 4'd3, 32'd2}));
        idle(2);

        // contention from pri=0: grants 0,1,0,1
        next_bundle(1);
        step();
        next_bundle(0);
        next_bundle(1);
        for (int k = 0; k < 4; k++) begin
            step();
            gseq[3 - k] = lastg[1];
            for (int i = 0; i < 2; i++) if (lastg[i]) next_bundle(i);
        end
        chk("cont_order", 96'(gseq), 96'(4'b0101));
        idle(3);

        // BLT -1 < 1 on port 1
        rq[1] = '{1'b1, OP_BLT, 32'h0, 2'd0, 12'h0, 20'h0,
                  32'hFFFF_FFFF, 32'd1, 4'd7};
        step();
        rq[1].valid = 1'b0;
        step();
        chk("branch_rsp",
            96'({rsp_valid, rsp_port, rsp_tag, rsp_take_branch}),
            96'({1'b1, 1'b1, 4'd7, 1'b1}));
        idle(2);

        // hold with both ports valid, then release
        next_bundle(0);
        next_bundle(1);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) step();
        hold = 1'b0;
        step();
        idle(3);

        // flush kills op in stage 1 and blocks the grant
        next_bundle(0);
        step();
        next_bundle(0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        rq[0].valid = 1'b0;
        chk("flush_t2", 96'(rsp_valid), 96'(0));
        step();
        chk("flush_t3", 96'(rsp_valid), 96'(0));
        idle(2);

        // async reset with two ops in flight
        next_bundle(0);
        step();
        next_bundle(0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp", 96'(rsp_valid), 96'(0));
        chk("arst_ready", 96'({req0.ready, req1.ready}), 96'(0));
        chk("arst_alu", 96'({alu_control, alu_in_1}), 96'(0));
        q.delete();
        m_pri = 1'b0;
        step();
        rst_n = 1'b1;
        next_bundle(0);
        next_bundle(1);
        step();
        chk("arst_first", 96'({lastg[1], lastg[0]}), 96'(2'b01));
        idle(4);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(rq[i].valid && !lastg[i])) begin
                    if ($urandom_range(0, 3) != 0) next_bundle(i);
                    else rq[i].valid = 1'b0;
                end
            end
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        hold  = 1'b0;
        flush = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
